// File: rtl/myproject_div_15s_8ns_7s_seq.sv
// Iterative restoring divider: signed 15-bit dividend by unsigned 8-bit divisor,
// saturating signed 7-bit quotient, one quotient bit per clock-enabled step.
module myproject_div_15s_8ns_7s_seq #(
   parameter int ID         = 1,
   parameter int din0_WIDTH = 15,
   parameter int din1_WIDTH = 8,
   parameter int dout_WIDTH = 7
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ce,
   input  logic                  start,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic                  busy,
   output logic                  done,
   output logic [dout_WIDTH-1:0] dout,
   output logic [din1_WIDTH:0]   rem,
   output logic                  ovf,
   output logic                  dbz
);

   localparam int CW = $clog2(din0_WIDTH + 1);
   localparam int QW = din0_WIDTH + 1;
   localparam int RW = din1_WIDTH + 1;

   localparam logic [CW-1:0]         CNT_LOAD = CW'(din0_WIDTH);
   localparam logic signed [QW-1:0]  Q_MAX    = QW'((2 ** (dout_WIDTH - 1)) - 1);
   localparam logic signed [QW-1:0]  Q_MIN    = QW'(-(2 ** (dout_WIDTH - 1)));
   localparam logic [dout_WIDTH-1:0] DOUT_MAX = {1'b0, {(dout_WIDTH - 1){1'b1}}};
   localparam logic [dout_WIDTH-1:0] DOUT_MIN = {1'b1, {(dout_WIDTH - 1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic                    sign_q, sign_d;
   logic                    dbz_sel_q, dbz_sel_d;
   logic [din0_WIDTH-1:0]   quo_q, quo_d;
   logic [din1_WIDTH-1:0]   div_q, div_d;
   logic [RW-1:0]           prem_q, prem_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic [dout_WIDTH-1:0]   dout_q, dout_d;
   logic [RW-1:0]           rem_q, rem_d;
   logic                    ovf_q, ovf_d;
   logic                    dbz_q, dbz_d;

   logic [din0_WIDTH-1:0]   abs_din0;
   logic [RW-1:0]           shifted;
   logic [RW:0]             trial;
   logic signed [QW-1:0]    q_signed;
   logic [RW-1:0]           r_signed;

   // quo_q starts as |dividend| and is shifted left while quotient bits fill in from the LSB
   always_comb begin
      abs_din0 = din0[din0_WIDTH-1] ? (~din0 + 1'b1) : din0;
      shifted  = {prem_q[din1_WIDTH-1:0], quo_q[din0_WIDTH-1]};
      trial    = {1'b0, shifted} - {2'b00, div_q};
      q_signed = sign_q ? -$signed({1'b0, quo_q}) : $signed({1'b0, quo_q});
      r_signed = sign_q ? (~prem_q + 1'b1) : prem_q;
   end

   always_comb begin
      state_d   = state_q;
      sign_d    = sign_q;
      dbz_sel_d = dbz_sel_q;
      quo_d     = quo_q;
      div_d     = div_q;
      prem_d    = prem_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      done_d    = done_q;
      dout_d    = dout_q;
      rem_d     = rem_q;
      ovf_d     = ovf_q;
      dbz_d     = dbz_q;

      case (state_q)
         IDLE: begin
            done_d = 1'b0;
            if (start) begin
               sign_d    = din0[din0_WIDTH-1];
               quo_d     = abs_din0;
               div_d     = din1;
               prem_d    = '0;
               cnt_d     = CNT_LOAD;
               busy_d    = 1'b1;
               dbz_sel_d = (din1 == '0);
               state_d   = (din1 == '0) ? FIX : CALC;
            end
         end

         CALC: begin
            if (!trial[RW]) begin
               prem_d = trial[RW-1:0];
               quo_d  = {quo_q[din0_WIDTH-2:0], 1'b1};
            end else begin
               prem_d = shifted;
               quo_d  = {quo_q[din0_WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
               state_d = FIX;
            end
         end

         FIX: begin
            if (dbz_sel_q) begin
               dout_d = sign_q ? DOUT_MIN : DOUT_MAX;
               rem_d  = '0;
               ovf_d  = 1'b0;
               dbz_d  = 1'b1;
            end else begin
               // saturate only after the sign has been applied, so -64 is not an overflow
               if (q_signed > Q_MAX) begin
                  dout_d = DOUT_MAX;
                  ovf_d  = 1'b1;
               end else if (q_signed < Q_MIN) begin
                  dout_d = DOUT_MIN;
                  ovf_d  = 1'b1;
               end else begin
                  dout_d = q_signed[dout_WIDTH-1:0];
                  ovf_d  = 1'b0;
               end
               rem_d = r_signed;
               dbz_d = 1'b0;
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         sign_q    <= 1'b0;
         dbz_sel_q <= 1'b0;
         quo_q     <= '0;
         div_q     <= '0;
         prem_q    <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dout_q    <= '0;
         rem_q     <= '0;
         ovf_q     <= 1'b0;
         dbz_q     <= 1'b0;
      end else if (ce) begin
         state_q   <= state_d;
         sign_q    <= sign_d;
         dbz_sel_q <= dbz_sel_d;
         quo_q     <= quo_d;
         div_q     <= div_d;
         prem_q    <= prem_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         dout_q    <= dout_d;
         rem_q     <= rem_d;
         ovf_q     <= ovf_d;
         dbz_q     <= dbz_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign dout = dout_q;
   assign rem  = rem_q;
   assign ovf  = ovf_q;
   assign dbz  = dbz_q;

endmodule
